// File: rtl/gemm_pkg.sv
// Shared widths and arithmetic helpers for the GEMM dot-product PE.
package gemm_pkg;

    // Product and tree widths for the default 8x8, 16-lane configuration.
    localparam int unsigned PROD_W = 16;
    localparam int unsigned TREE_W = 20;

    // Working width of sat_add; accumulators must be narrower than this.
    localparam int unsigned SAT_W = 64;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Signed add checked against a w-bit range. Returns {ovf, sum}; the caller keeps the
    // low w bits, so the non-saturating case wraps naturally.
    function automatic logic [SAT_W:0] sat_add(input logic signed [SAT_W-1:0] a,
                                               input logic signed [SAT_W-1:0] b,
                                               input int unsigned w,
                                               input logic sat);
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic ovf;
        sum = a + b;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (w - 1));
        ovf = (sum > hi) || (sum < lo);
        if (ovf && sat) begin
            sum = sum[SAT_W-1] ? lo : hi;
        end
        return {ovf, sum};
    endfunction

endpackage

// File: rtl/gemm_mul_lane.sv
// One signed lane multiplier with a registered product (pipeline stage S1).
module gemm_mul_lane
    import gemm_pkg::*;
#(
    parameter int unsigned INP_WIDTH = 8,
    parameter int unsigned WGT_WIDTH = 8,
    parameter bit          USE_DSP   = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic signed [INP_WIDTH-1:0]         a,
    input  logic signed [WGT_WIDTH-1:0]         b,
    output logic signed [INP_WIDTH+WGT_WIDTH-1:0] p
);

    localparam int unsigned W = INP_WIDTH + WGT_WIDTH;

    logic signed [W-1:0] prod;

    // Full-width signed product; both operands sign-extended to the product width.
    assign prod = $signed({{WGT_WIDTH{a[INP_WIDTH-1]}}, a}) *
                  $signed({{INP_WIDTH{b[WGT_WIDTH-1]}}, b});

    if (USE_DSP) begin : g_dsp
        (* use_dsp = "yes" *) logic signed [W-1:0] p_q;
        // Product register, mapped onto a DSP slice.
        always_ff @(posedge clk) begin
            if (rst) begin
                p_q <= '0;
            end else if (en) begin
                p_q <= prod;
            end
        end
        assign p = p_q;
    end else begin : g_fabric
        (* use_dsp = "no" *) logic signed [W-1:0] p_q;
        // Product register, kept in LUT fabric.
        always_ff @(posedge clk) begin
            if (rst) begin
                p_q <= '0;
            end else if (en) begin
                p_q <= prod;
            end
        end
        assign p = p_q;
    end

endmodule

// File: rtl/gemm_dot_pe.sv
// Pipelined signed dot-product PE: S1 lane products, S2 adder tree, S3 accumulate/output.
module gemm_dot_pe
    import gemm_pkg::*;
#(
    parameter int unsigned INP_WIDTH = 8,
    parameter int unsigned WGT_WIDTH = 8,
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned LANES     = 16,
    parameter bit          USE_DSP   = 1'b1,
    parameter bit          SATURATE  = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic [LANES*INP_WIDTH-1:0]   inp,
    input  logic [LANES*WGT_WIDTH-1:0]   wgt,
    input  logic [ACC_WIDTH-1:0]         acc_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_WIDTH-1:0]         out_sum,
    output logic                         out_ovf
);

    localparam int unsigned ProdW = INP_WIDTH + WGT_WIDTH;
    localparam int unsigned TreeW = ProdW + clog2(LANES);
    localparam int unsigned NodeN = 2 * LANES - 1;

    logic                        stall;
    logic signed [ProdW-1:0]     prod [LANES];
    logic signed [TreeW-1:0]     node [NodeN];

    logic                        s1_valid_q, s1_first_q, s1_last_q;
    logic signed [ACC_WIDTH-1:0] s1_acc_q;
    logic                        s2_valid_q, s2_first_q, s2_last_q;
    logic signed [ACC_WIDTH-1:0] s2_acc_q, s2_sum_q;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic                        sticky_q;
    logic                        out_valid_q, out_ovf_q;
    logic [ACC_WIDTH-1:0]        out_sum_q;

    logic signed [ACC_WIDTH-1:0] base, nxt;
    logic                        sticky_base, beat_ovf;
    logic [SAT_W:0]              add_res;
    logic [SAT_W-ACC_WIDTH-1:0]  unused_hi;

    // A held result freezes the whole pipeline.
    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        gemm_mul_lane #(
            .INP_WIDTH (INP_WIDTH),
            .WGT_WIDTH (WGT_WIDTH),
            .USE_DSP   (USE_DSP)
        ) u_mul (
            .clk (clk),
            .rst (rst),
            .en  (!stall),
            .a   (inp[i*INP_WIDTH +: INP_WIDTH]),
            .b   (wgt[i*WGT_WIDTH +: WGT_WIDTH]),
            .p   (prod[i])
        );
    end

    // Binary adder tree laid out as a heap: leaves at the top, root at node[0].
    always_comb begin
        node = '{default: '0};
        for (int i = 0; i < int'(LANES); i++) begin
            node[int'(LANES) - 1 + i] = TreeW'(prod[i]);
        end
        for (int i = int'(LANES) - 2; i >= 0; i--) begin
            node[i] = node[2*i+1] + node[2*i+2];
        end
    end

    // S1 sideband and S2 tree-sum registers; everything holds during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_acc_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_acc_q   <= '0;
            s2_sum_q   <= '0;
        end else if (!stall) begin
            s1_valid_q <= in_valid;
            s1_first_q <= in_first;
            s1_last_q  <= in_last;
            s1_acc_q   <= acc_in;
            s2_valid_q <= s1_valid_q;
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
            s2_acc_q   <= s1_acc_q;
            s2_sum_q   <= ACC_WIDTH'(node[0]);
        end
    end

    // S3 next value: a first beat reseeds the sum and clears the sticky overflow.
    always_comb begin
        base        = s2_first_q ? s2_acc_q : acc_q;
        sticky_base = s2_first_q ? 1'b0 : sticky_q;
        add_res     = sat_add(SAT_W'(base), SAT_W'(s2_sum_q), ACC_WIDTH, SATURATE);
        beat_ovf    = add_res[SAT_W];
        nxt         = add_res[ACC_WIDTH-1:0];
        unused_hi   = add_res[SAT_W-1:ACC_WIDTH];
    end

    // S3 accumulator and output register; a retiring last beat reloads the output even
    // while the previous result is being consumed, so no bubble is inserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else if (!stall) begin
            if (s2_valid_q) begin
                acc_q    <= nxt;
                sticky_q <= sticky_base | beat_ovf;
            end
            if (s2_valid_q && s2_last_q) begin
                out_valid_q <= 1'b1;
                out_sum_q   <= nxt;
                out_ovf_q   <= sticky_base | beat_ovf;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;

endmodule
